multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 144 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle RV32I(+M) control unit sequencing fetch/decode/execute/mem/writeback.
// Ports: clk, rst_n (async active-low); instr/icache_ready/dcache_ready/branch_taken in;
// fetch_req, ir_write, pc_write, pc_sel, alu_operation_type, alu_src_imm, dmem_read, dmem_write,
// reg_write, wb_sel, branch_operation_type, panic, state, retired_count out.
module multicycle_control_fsm #(
  parameter int ALU_OP_W    = 4,
  parameter bit MUL_ENABLE  = 1,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                icache_ready,
  input  logic                dcache_ready,
  input  logic                branch_taken,
  output logic                fetch_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic [ALU_OP_W-1:0] alu_operation_type,
  output logic                alu_src_imm,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic [3:0]          branch_operation_type,
  output logic                panic,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired_count
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
  state_t cur, nxt;
  logic [31:0] ir;
  logic [3:0] mul_cnt;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_r, r_add, r_sub, r_and, r_or, is_mul, is_i, i_add, i_and, i_or;
  logic is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, legal, imm_op, retire;
  logic [ALU_OP_W-1:0] alu_code;
  logic [3:0] bop;
  logic [1:0] wb_code;
  logic unused_fields;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign unused_fields = ^{ir[24:15], ir[11:7]};
  assign is_r = op == 7'h33;
  assign r_add = is_r && f7 == 7'h00 && f3 == 3'd0;
  assign r_sub = is_r && f7 == 7'h20 && f3 == 3'd0;
  assign r_and = is_r && f7 == 7'h00 && f3 == 3'd7;
  assign r_or = is_r && f7 == 7'h00 && f3 == 3'd6;
  assign is_mul = MUL_ENABLE && is_r && f7 == 7'h01 && f3 == 3'd0;
  assign is_i = op == 7'h13;
  assign i_add = is_i && f3 == 3'd0;
  assign i_and = is_i && f3 == 3'd7;
  assign i_or = is_i && f3 == 3'd6;
  assign is_lw = op == 7'h03 && f3 == 3'd2;
  assign is_sw = op == 7'h23 && f3 == 3'd2;
  // funct3 0,1,4,5 are BEQ/BNE/BLT/BGE; the unsigned variants are not supported
  assign is_br = op == 7'h63 && !f3[1];
  assign is_jal = op == 7'h6f;
  assign is_jalr = op == 7'h67 && f3 == 3'd0;
  assign is_lui = op == 7'h37;
  assign is_auipc = op == 7'h17;
  assign legal = r_add | r_sub | r_and | r_or | is_mul | i_add | i_and | i_or | is_lw | is_sw |
                 is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign alu_code = ALU_OP_W'(is_mul ? 5 : (r_or | i_or) ? 4 : (r_and | i_and) ? 3 :
                    (r_sub | is_br) ? 2 : (r_add | i_add | is_lw | is_sw | is_auipc) ? 1 : 0);
  assign imm_op = is_i | is_lw | is_sw | is_auipc;
  assign bop = !is_br ? 4'd0 : f3 == 3'd0 ? 4'd1 : f3 == 3'd1 ? 4'd2 : f3 == 3'd4 ? 4'd3 : 4'd4;
  assign wb_code = is_lw ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
  assign retire = nxt == FETCH && (cur == EXECUTE || cur == MEM || cur == WRITEBACK);
  assign state = cur;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= FETCH;
      ir <= '0;
      panic <= 1'b0;
      mul_cnt <= '0;
      retired_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && icache_ready) ir <= instr;
      if (cur == DECODE && !legal) panic <= 1'b1;
      // MUL holds EXECUTE while the counter drains; loaded with latency-1 so the exit cycle counts
      mul_cnt <= (cur == DECODE && is_mul) ? 4'(MUL_LATENCY - 1) :
                 (cur == EXECUTE && mul_cnt != 4'd0) ? mul_cnt - 4'd1 : mul_cnt;
      if (retire) retired_count <= retired_count + 1'b1;
    end
  always_comb begin
    nxt = cur;
    fetch_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_sel = 2'd0;
    alu_operation_type = '0;
    alu_src_imm = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel = 2'd0;
    branch_operation_type = 4'd0;
    case (cur)
      FETCH: begin
        // gated by rst_n so every strobe is low while reset is held
        fetch_req = rst_n;
        ir_write = rst_n & icache_ready;
        pc_write = rst_n & icache_ready;
        nxt = icache_ready ? DECODE : FETCH;
      end
      DECODE: nxt = legal ? EXECUTE : HALT;
      EXECUTE: begin
        alu_operation_type = alu_code;
        alu_src_imm = imm_op;
        branch_operation_type = bop;
        if (mul_cnt == 4'd0) begin
          if (is_lw | is_sw) nxt = MEM;
          else if (is_br) begin
            nxt = FETCH;
            pc_write = branch_taken;
            pc_sel = 2'd1;
          end else begin
            nxt = WRITEBACK;
            pc_write = is_jal | is_jalr;
            pc_sel = is_jalr ? 2'd2 : is_jal ? 2'd1 : 2'd0;
          end
        end
      end
      MEM: begin
        dmem_read = is_lw;
        dmem_write = is_sw;
        nxt = !dcache_ready ? MEM : is_lw ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        wb_sel = wb_code;
        nxt = FETCH;
      end
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven, scoreboarded check of multicycle_control_fsm.
module tb_multicycle_control_fsm;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic icache_ready = 1'b0, dcache_ready = 1'b0, branch_taken = 1'b0;
  logic fetch_req, ir_write, pc_write, alu_src_imm, dmem_read, dmem_write, reg_write, panic;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_operation_type, branch_operation_type, retired_count;
  logic [2:0] state;
  logic fetch_req0, ir_write0, pc_write0, alu_src_imm0, dmem_read0, dmem_write0, reg_write0, panic0;
  logic [1:0] pc_sel0, wb_sel0;
  logic [3:0] alu_operation_type0, branch_operation_type0, retired_count0;
  logic [2:0] state0;

  multicycle_control_fsm #(.ALU_OP_W(4), .MUL_ENABLE(1), .MUL_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .icache_ready(icache_ready),
    .dcache_ready(dcache_ready), .branch_taken(branch_taken), .fetch_req(fetch_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .alu_operation_type(alu_operation_type), .alu_src_imm(alu_src_imm), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .branch_operation_type(branch_operation_type), .panic(panic), .state(state),
    .retired_count(retired_count));

  multicycle_control_fsm #(.ALU_OP_W(4), .MUL_ENABLE(0), .MUL_LATENCY(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .icache_ready(icache_ready),
    .dcache_ready(dcache_ready), .branch_taken(branch_taken), .fetch_req(fetch_req0),
    .ir_write(ir_write0), .pc_write(pc_write0), .pc_sel(pc_sel0),
    .alu_operation_type(alu_operation_type0), .alu_src_imm(alu_src_imm0), .dmem_read(dmem_read0),
    .dmem_write(dmem_write0), .reg_write(reg_write0), .wb_sel(wb_sel0),
    .branch_operation_type(branch_operation_type0), .panic(panic0), .state(state0),
    .retired_count(retired_count0));

  always #5 clk = ~clk;

  typedef struct {
    int cyc, exec, alu, imm, bop, pcw, pcs, rd, wr, rw, wbs, ret, fin, pan, fok, dbad;
  } obs_t;
  typedef struct {
    logic [31:0] ins;
    int taken, dlat;
    obs_t e;
  } vec_t;

  obs_t q[$];
  vec_t tbl[20];
  int vectors = 0, miscompares = 0;

  function automatic obs_t ex(input int cyc, exec, alu, imm, bop, pcw, pcs, rd, wr, rw, wbs);
    obs_t o;
    o = '{cyc: cyc, exec: exec, alu: alu, imm: imm, bop: bop, pcw: pcw, pcs: pcs, rd: rd, wr: wr,
          rw: rw, wbs: wbs, ret: 1, fin: 0, pan: 0, fok: 1, dbad: 0};
    return o;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic run(input logic [31:0] ins, input int taken, input int dlat, input obs_t e,
                     input string tag);
    obs_t o, x;
    int memc = 0;
    logic [3:0] start;
    bit done = 0;
    o = '{default: 0};
    q.push_back(e);
    start = retired_count;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      instr = ins;
      icache_ready = 1'b1;
      branch_taken = taken[0];
      dcache_ready = (state != 3'd3) || (memc == dlat);
      #1;
      if (c > 0 && (state == 3'd0 || state == 3'd5)) begin
        done = 1;
        icache_ready = 1'b0;
      end else begin
        o.cyc++;
        if (c == 0) o.fok = int'(state == 3'd0 && ir_write && pc_write && pc_sel == 2'd0);
        if (state == 3'd1 && (fetch_req | ir_write | pc_write | reg_write | dmem_read | dmem_write))
          o.dbad = 1;
        if (state == 3'd2) begin
          o.exec++;
          o.alu = int'(alu_operation_type);
          o.imm = int'(alu_src_imm);
          o.bop = int'(branch_operation_type);
          if (pc_write) begin
            o.pcw = 1;
            o.pcs = int'(pc_sel);
          end
        end
        if (state == 3'd3) begin
          o.rd += int'(dmem_read);
          o.wr += int'(dmem_write);
          memc++;
        end
        if (reg_write) begin
          o.rw++;
          o.wbs = int'(wb_sel);
        end
      end
    end
    icache_ready = 1'b0;
    if (!done) chk({tag, " timeout"}, 0, 1);
    o.fin = int'(state);
    o.pan = int'(panic);
    o.ret = int'(4'(retired_count - start));
    x = q.pop_front();
    chk({tag, " cycles"}, o.cyc, x.cyc);
    chk({tag, " exec_cycles"}, o.exec, x.exec);
    chk({tag, " alu_op"}, o.alu, x.alu);
    chk({tag, " alu_src_imm"}, o.imm, x.imm);
    chk({tag, " branch_op"}, o.bop, x.bop);
    chk({tag, " pc_write"}, o.pcw, x.pcw);
    chk({tag, " pc_sel"}, o.pcs, x.pcs);
    chk({tag, " dmem_read_cycles"}, o.rd, x.rd);
    chk({tag, " dmem_write_cycles"}, o.wr, x.wr);
    chk({tag, " reg_write_cycles"}, o.rw, x.rw);
    chk({tag, " wb_sel"}, o.wbs, x.wbs);
    chk({tag, " retired_delta"}, o.ret, x.ret);
    chk({tag, " final_state"}, o.fin, x.fin);
    chk({tag, " panic"}, o.pan, x.pan);
    chk({tag, " fetch_strobes"}, o.fok, x.fok);
    chk({tag, " decode_strobes"}, o.dbad, x.dbad);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    icache_ready = 1'b0;
    dcache_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " rst state"}, int'(state), 0);
    chk({tag, " rst panic"}, int'(panic), 0);
    chk({tag, " rst retired"}, int'(retired_count), 0);
    chk({tag, " rst strobes"}, int'({fetch_req, ir_write, pc_write, dmem_read, dmem_write, reg_write}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, " post-rst fetch_req"}, int'(fetch_req), 1);
    chk({tag, " post-rst state"}, int'(state), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t he;
    logic [3:0] frozen;
    tbl[0]  = '{32'h00500093, 0, 0, ex(4, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[1]  = '{32'h002081B3, 0, 0, ex(4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{32'h402081B3, 0, 0, ex(4, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[3]  = '{32'h0020F1B3, 0, 0, ex(4, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{32'h0020E1B3, 0, 0, ex(4, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[5]  = '{32'h022081B3, 0, 0, ex(7, 4, 5, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[6]  = '{32'h00507093, 0, 0, ex(4, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[7]  = '{32'h00506093, 0, 0, ex(4, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[8]  = '{32'h0000A283, 0, 3, ex(8, 1, 1, 1, 0, 0, 0, 4, 0, 1, 1)};
    tbl[9]  = '{32'h0050A223, 0, 0, ex(4, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{32'h0050A223, 0, 2, ex(6, 1, 1, 1, 0, 0, 0, 0, 3, 0, 0)};
    tbl[11] = '{32'h00208463, 1, 0, ex(3, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0)};
    tbl[12] = '{32'h00208463, 0, 0, ex(3, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{32'h00209463, 1, 0, ex(3, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0)};
    tbl[14] = '{32'h0020C463, 1, 0, ex(3, 1, 2, 0, 3, 1, 1, 0, 0, 0, 0)};
    tbl[15] = '{32'h0020D463, 0, 0, ex(3, 1, 2, 0, 4, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{32'h008000EF, 0, 0, ex(4, 1, 0, 0, 0, 1, 1, 0, 0, 1, 2)};
    tbl[17] = '{32'h000080E7, 0, 0, ex(4, 1, 0, 0, 0, 1, 2, 0, 0, 1, 2)};
    tbl[18] = '{32'h123452B7, 0, 0, ex(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3)};
    tbl[19] = '{32'h00001297, 0, 0, ex(4, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0)};

    do_reset("init");
    for (int i = 0; i < 20; i++) begin
      run(tbl[i].ins, tbl[i].taken, tbl[i].dlat, tbl[i].e, $sformatf("vec%0d", i));
      if (i == 5) begin
        chk("nomul state", int'(state0), 5);
        chk("nomul panic", int'(panic0), 1);
      end
    end

    do_reset("wrap");
    for (int i = 0; i < 15; i++) run(32'h00500093, 0, 0, tbl[0].e, "wrap_addi");
    chk("wrap count at 15", int'(retired_count), 15);
    run(32'h00500093, 0, 0, tbl[0].e, "wrap_last");
    chk("wrap count to 0", int'(retired_count), 0);

    do_reset("halt");
    run(32'h00500093, 0, 0, tbl[0].e, "pre_halt");
    he = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    he.ret = 0;
    he.fin = 5;
    he.pan = 1;
    run(32'hFFFFFFFF, 0, 0, he, "illegal");
    frozen = retired_count;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      icache_ready = c[0];
      dcache_ready = ~c[0];
      #1;
      chk("halt state", int'(state), 5);
      chk("halt panic", int'(panic), 1);
      chk("halt strobes", int'({fetch_req, ir_write, pc_write, dmem_read, dmem_write, reg_write}), 0);
      chk("halt retired frozen", int'(retired_count), int'(frozen));
    end
    do_reset("after_halt");

    run(32'h00500093, 0, 0, tbl[0].e, "pre_mem");
    @(negedge clk);
    instr = 32'h0000A283;
    icache_ready = 1'b1;
    dcache_ready = 1'b0;
    for (int c = 0; c < 10 && state != 3'd3; c++) begin
      @(negedge clk);
      #1;
    end
    chk("midmem state", int'(state), 3);
    chk("midmem dmem_read", int'(dmem_read), 1);
    chk("midmem retired", int'(retired_count), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midmem rst dmem_read", int'(dmem_read), 0);
    chk("midmem rst state", int'(state), 0);
    chk("midmem rst retired", int'(retired_count), 0);
    icache_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midmem post-rst fetch_req", int'(fetch_req), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
